fxp_smul_pipe: RTL

- Pipelined signed fixed-point multiplier, Q(QINT).(QFRAC) format, two's complement.
- Adds configurable rounding, saturation vs wrap on overflow, a per-result overflow flag and a sticky overflow flag.
- Fully pipelined with a valid/ready handshake on both sides, for use in datapaths that backpressure.
- Successor to the combinational fixed-point multiplier; drop-in wherever registered, flow-controlled products are needed.

---
 rtl/fxp_smul_pipe.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/fxp_smul_pipe.sv
// ---------------------------------------------------------------------------
// fxp_smul_pipe
//
// Pipelined signed fixed-point multiplier, Q(QINT).(QFRAC), two's complement.
// The exact 2W-bit product is formed in stage 0. Later stages only retime it,
// except the final stage, which rounds, shifts, saturates or wraps, and flags
// overflow. The valid/ready handshake on both sides uses one global stall:
// when the output is valid and not accepted, every stage holds.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset (internally released synchronously)
//   in_valid    operands valid
//   in_ready    block can accept operands this cycle
//   a, b        signed W-bit operands
//   out_valid   result valid
//   out_ready   downstream accepts result
//   out         signed W-bit product
//   out_ovf     overflow on this result (qualified by out_valid)
//   ovf_sticky  set by any transferred-out result that overflowed
//   ovf_clr     synchronous clear of ovf_sticky (a coincident set wins)
//
// STAGES must lie in 1..4.
// ---------------------------------------------------------------------------
module fxp_smul_pipe #(
    parameter int QINT   = 8,
    parameter int QFRAC  = 16,
    parameter int STAGES = 2,
    parameter int ROUND  = 1,
    parameter int SAT    = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [QINT+QFRAC-1:0]  a,
    input  logic signed [QINT+QFRAC-1:0]  b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [QINT+QFRAC-1:0]  out,
    output logic                          out_ovf,
    output logic                          ovf_sticky,
    input  logic                          ovf_clr
);

    localparam int W  = QINT + QFRAC;
    localparam int PW = 2 * W;

    // Rounding constant: half an LSB of the result, or nothing when truncating.
    localparam logic [PW:0] RND_K = (ROUND != 0) ? ((PW+1)'(1) << (QFRAC - 1)) : '0;

    // Returns {ovf, result}. The shifted value is PW+1 bits wide; it fits in
    // W bits only when bits [PW:W-1] are all equal (pure sign extension).
    function automatic logic [W:0] f_finish(input logic signed [PW-1:0] p);
        logic signed [PW:0] v_r;
        logic signed [PW:0] v_s;
        logic [W+1:0]       v_hi;
        logic               v_ovf;
        logic [W-1:0]       v_res;
        v_r   = $signed({p[PW-1], p}) + $signed(RND_K);
        v_s   = v_r >>> QFRAC;
        v_hi  = v_s[PW:W-1];
        v_ovf = !((&v_hi) || !(|v_hi));
        if (v_ovf && (SAT != 0)) begin
            v_res = v_s[PW] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            v_res = v_s[W-1:0];
        end
        return {v_ovf, v_res};
    endfunction

    // Reset synchronizer: assertion is immediate, release is aligned to clk
    // so that no register leaves reset on a different edge than its peers.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    logic                 w_stall;
    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] w_fin_p;    // product entering the final stage
    logic                 w_fin_vin;  // valid bit entering the final stage
    logic [W:0]           w_fin;
    logic [STAGES-1:0]    r_vld;
    logic signed [W-1:0]  r_out;
    logic                 r_ovf;
    logic                 r_sticky;

    assign w_stall   = r_vld[STAGES-1] && !out_ready;
    // Held low while the internal reset is still asserted so that nothing
    // is offered into registers that would drop it.
    assign in_ready  = !w_stall && w_rst_n;
    assign w_prod    = a * b;

    generate
        if (STAGES == 1) begin : g_one
            // The single register is the final stage; multiply and finish
            // both sit in front of it.
            assign w_fin_p   = w_prod;
            assign w_fin_vin = in_valid;

            always_ff @(posedge clk or negedge w_rst_n) begin
                if (!w_rst_n) begin
                    r_vld <= '0;
                end else if (!w_stall) begin
                    r_vld <= in_valid;
                end
            end
        end else begin : g_multi
            // r_p[0] is stage 0 (registered product); r_p[1..] only retime.
            logic signed [PW-1:0] r_p [STAGES-1];

            always_ff @(posedge clk or negedge w_rst_n) begin
                if (!w_rst_n) begin
                    r_vld <= '0;
                    for (int i = 0; i < STAGES - 1; i++) begin
                        r_p[i] <= '0;
                    end
                end else if (!w_stall) begin
                    r_vld  <= {r_vld[STAGES-2:0], in_valid};
                    r_p[0] <= w_prod;
                    for (int i = 1; i < STAGES - 1; i++) begin
                        r_p[i] <= r_p[i-1];
                    end
                end
            end

            assign w_fin_p   = r_p[STAGES-2];
            assign w_fin_vin = r_vld[STAGES-2];
        end
    endgenerate

    assign w_fin = f_finish(w_fin_p);

    // Final stage. The overflow flag is gated with the incoming valid so a
    // bubble never presents a stale overflow.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_out <= '0;
            r_ovf <= 1'b0;
        end else if (!w_stall) begin
            r_out <= w_fin[W-1:0];
            r_ovf <= w_fin[W] && w_fin_vin;
        end
    end

    // Sticky overflow: a transferred-out overflow takes priority over clear.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sticky <= 1'b0;
        end else if (r_vld[STAGES-1] && out_ready && r_ovf) begin
            r_sticky <= 1'b1;
        end else if (ovf_clr) begin
            r_sticky <= 1'b0;
        end
    end

    assign out_valid  = r_vld[STAGES-1];
    assign out        = r_out;
    assign out_ovf    = r_ovf;
    assign ovf_sticky = r_sticky;

endmodule
